m8c_issp_seq: RTL and testbench

//  Command sequencer in front of the M8C ISSP bit engine. Queues host-issued ISSP commands (vector, input mask, opcode).

---
 rtl/m8c_issp_pkg.sv | 25 ++
 rtl/m8c_issp_cmdq.sv | 56 +++++
 rtl/m8c_issp_seq.sv | 166 ++++++++++++++++
 tb/tb_m8c_issp_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m8c_issp_pkg.sv
// Shared definitions for the M8C ISSP command sequencer and bit engine:
// opcodes, vector width and sequencer state encoding.
package m8c_issp_pkg;

   localparam int ISSP_VEC_SIZE = 22;

   localparam logic [2:0] ISSPCMD_NONE    = 3'd0;
   localparam logic [2:0] ISSPCMD_POR     = 3'd1;
   localparam logic [2:0] ISSPCMD_PWROFF  = 3'd2;
   localparam logic [2:0] ISSPCMD_SENDVEC = 3'd3;
   localparam logic [2:0] ISSPCMD_EXEC    = 3'd4;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_START,
      SEQ_WAIT,
      SEQ_RESULT,
      SEQ_HALT
   } seq_state_t;

   function automatic logic issp_op_valid(input logic [2:0] op);
      return (op >= ISSPCMD_POR) && (op <= ISSPCMD_EXEC);
   endfunction

endpackage

// File: rtl/m8c_issp_cmdq.sv
// Synchronous command FIFO with first-word-fall-through head and a flush
// input that empties it in one cycle.
module m8c_issp_cmdq #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_empty,
   output logic         o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_FULL);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/m8c_issp_seq.sv
// ISSP command sequencer: queues host commands, runs them one at a time on
// the bit engine, captures SENDVEC read-back and aborts hung operations.
module m8c_issp_seq
   import m8c_issp_pkg::*;
#(
   parameter int VEC_W       = ISSP_VEC_SIZE,
   parameter int DEPTH       = 4,
   parameter int HOLDOFF     = 2,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic             osc,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [VEC_W-1:0] cmd_vec,
   input  logic [VEC_W-1:0] cmd_mask,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [VEC_W-1:0] res_data,
   output logic [2:0]       eng_cmd,
   output logic [VEC_W-1:0] eng_vec,
   output logic [VEC_W-1:0] eng_mask,
   output logic             eng_start,
   output logic             eng_abort,
   input  logic             eng_busy,
   input  logic [VEC_W-1:0] eng_rdata,
   output logic             idle,
   output logic             err_timeout,
   output logic             err_badcmd,
   input  logic             err_clr
);

   localparam int QW = 3 + 2 * VEC_W;
   localparam logic [15:0] HOLD_L  = 16'(HOLDOFF);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   seq_state_t       r_state;
   logic [15:0]      r_cnt;
   logic [2:0]       r_eng_cmd;
   logic [VEC_W-1:0] r_eng_vec;
   logic [VEC_W-1:0] r_eng_mask;
   logic             r_start;
   logic             r_abort;
   logic             r_res_valid;
   logic [VEC_W-1:0] r_res_data;
   logic             r_err_to;
   logic             r_err_bad;

   logic [QW-1:0]    w_head;
   logic [2:0]       w_head_op;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_flush;
   logic             w_done;
   logic             w_timeout;

   assign cmd_ready = !w_full && (r_state != SEQ_HALT);
   assign w_push    = cmd_valid && cmd_ready;
   assign w_pop     = (r_state == SEQ_IDLE) && !w_empty;
   assign w_head_op = w_head[QW-1 -: 3];

   // Busy is only trusted once the engine has had HOLDOFF cycles to see the start.
   assign w_done    = (r_state == SEQ_WAIT) && (r_cnt >= HOLD_L) && !eng_busy;
   assign w_timeout = (r_state == SEQ_WAIT) && !w_done && (r_cnt >= TO_LAST);
   assign w_flush   = w_timeout || (r_state == SEQ_HALT);

   m8c_issp_cmdq #(
      .W     (QW),
      .DEPTH (DEPTH)
   ) u_cmdq (
      .i_clk   (osc),
      .i_rst   (rst),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_data  ({cmd_op, cmd_vec, cmd_mask}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   always_ff @(posedge osc) begin
      if (rst) begin
         r_state     <= SEQ_IDLE;
         r_cnt       <= '0;
         r_eng_cmd   <= '0;
         r_eng_vec   <= '0;
         r_eng_mask  <= '0;
         r_start     <= 1'b0;
         r_abort     <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_err_to    <= 1'b0;
         r_err_bad   <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_abort <= 1'b0;
         if (err_clr && (r_state != SEQ_HALT)) r_err_bad <= 1'b0;

         case (r_state)
            SEQ_IDLE: begin
               if (!w_empty) begin
                  if (issp_op_valid(w_head_op)) begin
                     r_eng_cmd  <= w_head_op;
                     r_eng_vec  <= w_head[2*VEC_W-1 -: VEC_W];
                     r_eng_mask <= w_head[VEC_W-1:0];
                     r_start    <= 1'b1;
                     r_state    <= SEQ_START;
                  end else begin
                     r_err_bad <= 1'b1;
                  end
               end
            end
            SEQ_START: begin
               r_cnt   <= '0;
               r_state <= SEQ_WAIT;
            end
            SEQ_WAIT: begin
               if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
               if (w_done) begin
                  if (r_eng_cmd == ISSPCMD_SENDVEC) begin
                     r_res_data  <= eng_rdata;
                     r_res_valid <= 1'b1;
                     r_state     <= SEQ_RESULT;
                  end else begin
                     r_state <= SEQ_IDLE;
                  end
               end else if (w_timeout) begin
                  r_abort  <= 1'b1;
                  r_err_to <= 1'b1;
                  r_state  <= SEQ_HALT;
               end
            end
            SEQ_RESULT: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= SEQ_IDLE;
               end
            end
            SEQ_HALT: begin
               if (err_clr) begin
                  r_err_to  <= 1'b0;
                  r_err_bad <= 1'b0;
                  r_state   <= SEQ_IDLE;
               end
            end
            default: r_state <= SEQ_IDLE;
         endcase
      end
   end

   assign eng_cmd     = r_eng_cmd;
   assign eng_vec     = r_eng_vec;
   assign eng_mask    = r_eng_mask;
   assign eng_start   = r_start;
   assign eng_abort   = r_abort;
   assign res_valid   = r_res_valid;
   assign res_data    = r_res_data;
   assign err_timeout = r_err_to;
   assign err_badcmd  = r_err_bad;
   assign idle        = w_empty && (r_state == SEQ_IDLE);

endmodule

// File: tb/tb_m8c_issp_seq.sv
// Bench for m8c_issp_seq: behavioural engine model, result scoreboard and
// directed sequences for queueing, back-pressure, timeout, bad opcodes and reset.
module tb_m8c_issp_seq;
   import m8c_issp_pkg::*;

   localparam int VW = 22;
   localparam int TO = 100;

   logic          osc = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [VW-1:0] cmd_vec;
   logic [VW-1:0] cmd_mask;
   logic          res_valid;
   logic          res_ready;
   logic [VW-1:0] res_data;
   logic [2:0]    eng_cmd;
   logic [VW-1:0] eng_vec;
   logic [VW-1:0] eng_mask;
   logic          eng_start;
   logic          eng_abort;
   logic          eng_busy = 1'b0;
   logic [VW-1:0] eng_rdata = '0;
   logic          idle;
   logic          err_timeout;
   logic          err_badcmd;
   logic          err_clr;

   always #5 osc = ~osc;

   m8c_issp_seq #(
      .VEC_W       (VW),
      .DEPTH       (4),
      .HOLDOFF     (2),
      .TIMEOUT_CYC (TO)
   ) dut (
      .osc         (osc),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_vec     (cmd_vec),
      .cmd_mask    (cmd_mask),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .eng_cmd     (eng_cmd),
      .eng_vec     (eng_vec),
      .eng_mask    (eng_mask),
      .eng_start   (eng_start),
      .eng_abort   (eng_abort),
      .eng_busy    (eng_busy),
      .eng_rdata   (eng_rdata),
      .idle        (idle),
      .err_timeout (err_timeout),
      .err_badcmd  (err_badcmd),
      .err_clr     (err_clr)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Engine model: busy for m_lat cycles after a start, or forever when stuck.
   int            m_lat   = 4;
   logic          m_stuck = 1'b0;
   logic [VW-1:0] m_rdata = '0;
   int            m_left  = 0;

   always @(negedge osc) begin
      if (rst || eng_abort) begin
         eng_busy = 1'b0;
         m_left   = 0;
      end else if (eng_start) begin
         eng_busy  = 1'b1;
         m_left    = m_lat;
         eng_rdata = m_rdata;
      end else if (eng_busy && !m_stuck) begin
         m_left--;
         if (m_left <= 0) eng_busy = 1'b0;
      end
   end

   // Monitor: pulse counting and result scoreboard.
   logic [VW-1:0] exp_res[$];
   int   cyc = 0, n_start = 0, n_wide_start = 0, n_wide_abort = 0;
   int   t_start = 0, t_abort = 0;
   logic p_start = 1'b0, p_abort = 1'b0, p_rv = 1'b0;
   logic [VW-1:0] exp_front;

   always @(negedge osc) begin
      cyc++;
      if (eng_start) begin
         n_start++;
         t_start = cyc;
         if (p_start) n_wide_start++;
      end
      if (eng_abort) begin
         t_abort = cyc;
         if (p_abort) n_wide_abort++;
      end
      if (res_valid && !p_rv) begin
         if (exp_res.size() == 0) begin
            chk("res_unexpected", 32'(res_data), 32'hFFFF_FFFF);
         end else begin
            exp_front = exp_res.pop_front();
            $display("result data=0x%06h expected=0x%06h", res_data, exp_front);
            chk("res_data", 32'(res_data), 32'(exp_front));
         end
      end
      p_start = eng_start;
      p_abort = eng_abort;
      p_rv    = res_valid;
   end

   task automatic push_cmd(input logic [2:0] op, input logic [VW-1:0] vec, input logic [VW-1:0] mask);
      int t = 0;
      while (!cmd_ready && t < 2000) begin
         @(negedge osc);
         t++;
      end
      if (!cmd_ready) begin
         chk("push_ready_timeout", 32'(cmd_ready), 32'd1);
         return;
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_vec   = vec;
      cmd_mask  = mask;
      if (op == ISSPCMD_SENDVEC) exp_res.push_back(m_rdata);
      $display("push op=%0d vec=0x%06h mask=0x%06h", op, vec, mask);
      @(negedge osc);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (!(idle === 1'b1 && res_valid === 1'b0) && t < 2000) begin
         @(negedge osc);
         t++;
      end
      chk({tag, "_idle"}, 32'(idle), 32'd1);
   endtask

   task automatic wait_res(input string tag);
      int t = 0;
      while (res_valid !== 1'b1 && t < 500) begin
         @(negedge osc);
         t++;
      end
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got simulation still running, expected finish");
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      int s0;
      int bad;
      int n;

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_vec = '0; cmd_mask = '0;
      res_ready = 1'b1; err_clr = 1'b0;
      repeat (3) @(negedge osc);

      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_eng_cmd", 32'(eng_cmd), 32'd0);
      chk("rst_eng_vec", 32'(eng_vec), 32'd0);
      chk("rst_eng_mask", 32'(eng_mask), 32'd0);
      chk("rst_eng_start", 32'(eng_start), 32'd0);
      chk("rst_eng_abort", 32'(eng_abort), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_err_timeout", 32'(err_timeout), 32'd0);
      chk("rst_err_badcmd", 32'(err_badcmd), 32'd0);
      rst = 1'b0;
      @(negedge osc);

      // POR then SENDVEC with a slow engine.
      m_lat = 50; m_rdata = 22'h0ABCDE;
      s0 = n_start;
      push_cmd(ISSPCMD_POR, '0, '0);
      push_cmd(ISSPCMD_SENDVEC, 22'h2AAAAA, '0);
      wait_idle("t1");
      chk("t1_starts", 32'(n_start - s0), 32'd2);
      chk("t1_eng_cmd", 32'(eng_cmd), 32'(ISSPCMD_SENDVEC));
      chk("t1_eng_vec", 32'(eng_vec), 32'h2AAAAA);

      // Result held until the host takes it; nothing else starts meanwhile.
      res_ready = 1'b0; m_lat = 5; m_rdata = 22'h3000A5;
      push_cmd(ISSPCMD_SENDVEC, 22'h000001, 22'h0000FF);
      push_cmd(ISSPCMD_PWROFF, '0, '0);
      wait_res("t2");
      chk("t2_eng_mask", 32'(eng_mask), 32'h0000FF);
      s0 = n_start; bad = 0;
      repeat (10) begin
         @(negedge osc);
         if (!(res_valid === 1'b1 && res_data === 22'h3000A5)) bad++;
      end
      chk("t2_res_hold", 32'(bad), 32'd0);
      chk("t2_no_start_pending", 32'(n_start - s0), 32'd0);
      res_ready = 1'b1;
      wait_idle("t2");
      chk("t2_next_start", 32'(n_start - s0), 32'd1);

      // Queue fill while the sequencer is parked on a pending result.
      res_ready = 1'b0; m_lat = 3; m_rdata = 22'h155555;
      push_cmd(ISSPCMD_SENDVEC, 22'h3FFFFF, 22'h3FFFFF);
      wait_res("t3");
      s0 = n_start;
      push_cmd(ISSPCMD_PWROFF, '0, '0);
      push_cmd(ISSPCMD_POR, '0, '0);
      push_cmd(ISSPCMD_EXEC, 22'h000011, '0);
      push_cmd(ISSPCMD_PWROFF, '0, '0);
      chk("t3_full_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b1; cmd_op = ISSPCMD_EXEC; n = 0;
      repeat (5) begin
         @(negedge osc);
         if (cmd_ready) n++;
      end
      cmd_valid = 1'b0;
      chk("t3_fifth_blocked", 32'(n), 32'd0);
      chk("t3_no_start", 32'(n_start - s0), 32'd0);
      res_ready = 1'b1;
      push_cmd(ISSPCMD_EXEC, 22'h000022, '0);
      wait_idle("t3");
      chk("t3_starts", 32'(n_start - s0), 32'd5);

      // Watchdog: engine stuck busy.
      m_stuck = 1'b1; m_lat = 3;
      s0 = n_start;
      push_cmd(ISSPCMD_EXEC, 22'h000033, '0);
      push_cmd(ISSPCMD_PWROFF, '0, '0);
      push_cmd(ISSPCMD_PWROFF, '0, '0);
      n = 0;
      while (err_timeout !== 1'b1 && n < 400) begin
         @(negedge osc);
         n++;
      end
      chk("t4_err_timeout", 32'(err_timeout), 32'd1);
      chk("t4_abort_with_flag", 32'(eng_abort), 32'd1);
      chk("t4_halt_ready", 32'(cmd_ready), 32'd0);
      chk("t4_halt_idle", 32'(idle), 32'd0);
      @(negedge osc);
      // Counter reaches TO at the edge after WAIT cycle TO; abort shows in the cycle after that edge.
      chk("t4_abort_latency", 32'(t_abort - t_start), 32'(TO + 1));
      chk("t4_abort_pulse", 32'(eng_abort), 32'd0);
      repeat (5) @(negedge osc);
      chk("t4_halt_hold_ready", 32'(cmd_ready), 32'd0);
      m_stuck = 1'b0;
      err_clr = 1'b1;
      @(negedge osc);
      err_clr = 1'b0;
      chk("t4_clr_idle", 32'(idle), 32'd1);
      chk("t4_clr_ready", 32'(cmd_ready), 32'd1);
      chk("t4_clr_err_timeout", 32'(err_timeout), 32'd0);
      repeat (5) @(negedge osc);
      chk("t4_flushed_starts", 32'(n_start - s0), 32'd1);

      // Invalid opcode between two PWROFFs.
      m_lat = 3;
      s0 = n_start;
      push_cmd(ISSPCMD_PWROFF, '0, '0);
      push_cmd(3'd7, 22'h000044, '0);
      push_cmd(ISSPCMD_PWROFF, '0, '0);
      wait_idle("t5");
      chk("t5_err_badcmd", 32'(err_badcmd), 32'd1);
      chk("t5_starts", 32'(n_start - s0), 32'd2);
      err_clr = 1'b1;
      @(negedge osc);
      err_clr = 1'b0;
      chk("t5_badcmd_cleared", 32'(err_badcmd), 32'd0);
      m_rdata = 22'h2F0F0F;
      push_cmd(ISSPCMD_SENDVEC, 22'h00F0F0, 22'h3FFFFF);
      wait_idle("t5b");

      // Reset in the middle of WAIT.
      m_lat = 50;
      push_cmd(ISSPCMD_EXEC, 22'h000055, '0);
      push_cmd(ISSPCMD_PWROFF, '0, '0);
      repeat (8) @(negedge osc);
      chk("t6_pre_idle", 32'(idle), 32'd0);
      rst = 1'b1;
      @(negedge osc);
      chk("t6_idle", 32'(idle), 32'd1);
      chk("t6_eng_start", 32'(eng_start), 32'd0);
      chk("t6_eng_abort", 32'(eng_abort), 32'd0);
      chk("t6_res_valid", 32'(res_valid), 32'd0);
      chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b0;
      s0 = n_start;
      repeat (5) @(negedge osc);
      chk("t6_no_start_after", 32'(n_start - s0), 32'd0);

      chk("start_pulse_width", 32'(n_wide_start), 32'd0);
      chk("abort_pulse_width", 32'(n_wide_abort), 32'd0);
      chk("scoreboard_empty", 32'(exp_res.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
